// File: rtl/lmfe_scan_ctrl.sv
// Raster-scan controller for a 7x7 median window: paces host pixels into an
// 8-row line buffer and issues CLEAR/INSERT/ERASE/READ commands to the sort engine.
module lmfe_scan_ctrl #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_en,
    output logic       busy,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic       op_valid,
    output logic [1:0] op_code,
    output logic [6:0] op_row,
    output logic [6:0] op_col,
    output logic       op_pad,
    output logic       done
);
    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_ERASE  = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;
    localparam logic [6:0] LAST_COL  = 7'(IMG_W - 1);
    localparam logic [6:0] LAST_ROW  = 7'(IMG_H - 1);
    localparam logic signed [8:0] W_S = 9'(IMG_W);
    localparam logic signed [8:0] H_S = 9'(IMG_H);

    typedef enum logic [2:0] {IDLE, WAIT_IN, CLEAR, FILL, SLIDE, READ, DONE} state_t;

    state_t      state, state_n;
    logic [14:0] in_cnt;
    logic [2:0]  in_row;
    logic [6:0]  in_col;
    logic [6:0]  r, c, r_n, c_n;
    // wy: window row offset 0..6; wx: column offset 0..6 in FILL, erase/insert phase in SLIDE
    logic [2:0]  wy, wx, wy_n, wx_n;
    logic [7:0]  r3, c3;
    logic [14:0] need_row, need_col, need;

    logic                vld_n, pad_n;
    logic [1:0]          code_n;
    logic signed [8:0]   orow, ocol;

    // Pixels required before window (r,c) is complete, clamped at the image edge
    assign r3       = {1'b0, r} + 8'd3;
    assign c3       = {1'b0, c} + 8'd3;
    assign need_row = (r3 > 8'(IMG_H - 1)) ? 15'(IMG_H - 1) : 15'(r3);
    assign need_col = (c3 > 8'(IMG_W - 1)) ? 15'(IMG_W - 1) : 15'(c3);
    assign need     = need_row * 15'(IMG_W) + need_col + 15'd1;

    assign busy    = (state == DONE) || (in_cnt >= need);
    assign wr_en   = in_en & ~busy;
    assign wr_addr = {in_row, in_col};

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt <= '0;
            in_row <= '0;
            in_col <= '0;
        end else if (wr_en) begin
            in_cnt <= in_cnt + 15'd1;
            if (in_col == LAST_COL) begin
                in_col <= '0;
                in_row <= in_row + 3'd1;
            end else begin
                in_col <= in_col + 7'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        wy_n    = wy;
        wx_n    = wx;
        case (state)
            IDLE: if (wr_en) state_n = WAIT_IN;
            WAIT_IN: begin
                if (in_cnt >= need) begin
                    state_n = (c == 7'd0) ? CLEAR : SLIDE;
                    wy_n    = '0;
                    wx_n    = '0;
                end
            end
            CLEAR: begin
                state_n = FILL;
                wy_n    = '0;
                wx_n    = '0;
            end
            FILL: begin
                if (wx == 3'd6) begin
                    wx_n = '0;
                    if (wy == 3'd6) state_n = READ;
                    else            wy_n = wy + 3'd1;
                end else begin
                    wx_n = wx + 3'd1;
                end
            end
            SLIDE: begin
                if (wx[0]) begin
                    wx_n = '0;
                    if (wy == 3'd6) state_n = READ;
                    else            wy_n = wy + 3'd1;
                end else begin
                    wx_n = 3'd1;
                end
            end
            READ: begin
                if (r == LAST_ROW && c == LAST_COL) begin
                    state_n = DONE;
                end else begin
                    state_n = WAIT_IN;
                    if (c == LAST_COL) begin
                        c_n = '0;
                        r_n = r + 7'd1;
                    end else begin
                        c_n = c + 7'd1;
                    end
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Command for the upcoming state, so op_* lines up with the state it belongs to
    always_comb begin
        vld_n  = 1'b0;
        code_n = OP_CLEAR;
        orow   = '0;
        ocol   = '0;
        case (state_n)
            CLEAR: vld_n = 1'b1;
            FILL: begin
                vld_n  = 1'b1;
                code_n = OP_INSERT;
                orow   = $signed({2'b00, r_n}) - 9'sd3 + $signed({6'b0, wy_n});
                ocol   = $signed({2'b00, c_n}) - 9'sd3 + $signed({6'b0, wx_n});
            end
            SLIDE: begin
                vld_n  = 1'b1;
                code_n = wx_n[0] ? OP_INSERT : OP_ERASE;
                orow   = $signed({2'b00, r_n}) - 9'sd3 + $signed({6'b0, wy_n});
                ocol   = wx_n[0] ? ($signed({2'b00, c_n}) + 9'sd3)
                                 : ($signed({2'b00, c_n}) - 9'sd4);
            end
            READ: begin
                vld_n  = 1'b1;
                code_n = OP_READ;
                orow   = $signed({2'b00, r_n});
                ocol   = $signed({2'b00, c_n});
            end
            default: vld_n = 1'b0;
        endcase
        pad_n = vld_n && (orow[8] || ocol[8] || (orow >= H_S) || (ocol >= W_S));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            wy       <= '0;
            wx       <= '0;
            op_valid <= 1'b0;
            op_code  <= '0;
            op_row   <= '0;
            op_col   <= '0;
            op_pad   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            r        <= r_n;
            c        <= c_n;
            wy       <= wy_n;
            wx       <= wx_n;
            op_valid <= vld_n;
            op_code  <= code_n;
            op_row   <= pad_n ? 7'd0 : orow[6:0];
            op_col   <= pad_n ? 7'd0 : ocol[6:0];
            op_pad   <= pad_n;
            done     <= (state_n == DONE);
        end
    end
endmodule
